// File: rtl/fuzz_exception_recorder_if.sv
// Exception record stream: core-side pulse in, host-side valid/ready record out.
interface fuzz_exception_recorder_if;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_tval;
    logic [31:0] exc_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_code;
    logic [31:0] out_tval;
    logic [31:0] out_pc;

    modport master (
        output exc_valid, exc_code, exc_tval, exc_pc, out_ready,
        input  out_valid, out_code, out_tval, out_pc
    );

    modport slave (
        input  exc_valid, exc_code, exc_tval, exc_pc, out_ready,
        output out_valid, out_code, out_tval, out_pc
    );
endinterface

// File: rtl/fuzz_exception_recorder.sv
// Records core exception pulses into a first-word-fall-through FIFO for the host; push-to-out_valid latency 1 cycle.
// No backpressure on exceptions: a push into a full FIFO (without a same-cycle pop) is dropped and counted; dexie_stall warns early.
module fuzz_exception_recorder #(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    fuzz_exception_recorder_if.slave    bus,
    input  logic                        clear,
    output logic                        dexie_stall,
    output logic [31:0]                 exc_count,
    output logic [15:0]                 drop_count,
    output logic                        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_OCC = (AW+1)'(DEPTH - STALL_MARGIN);

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] tval;
        logic [31:0] pc;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [AW:0]   occ_next;
    logic          pop;
    logic          accept;
    logic          reject;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign pop    = bus.out_valid && bus.out_ready;
    assign accept = bus.exc_valid && ((occ != FULL_OCC) || pop);
    assign reject = bus.exc_valid && !accept;

    always_comb begin
        occ_next = occ;
        case ({accept, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            dexie_stall <= 1'b0;
            exc_count   <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ         <= occ_next;
            dexie_stall <= (occ_next >= STALL_OCC);
            if (accept && (exc_count != '1)) begin
                exc_count <= exc_count + 1'b1;
            end
            if (reject) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left out of reset; stale words are masked by out_valid.
    always_ff @(posedge clk) begin
        if (accept && !rst && !clear) begin
            mem[wr_ptr] <= '{code: bus.exc_code, tval: bus.exc_tval, pc: bus.exc_pc};
        end
    end

    assign head          = mem[rd_ptr];
    assign bus.out_valid = (occ != '0);
    assign bus.out_code  = bus.out_valid ? head.code : '0;
    assign bus.out_tval  = bus.out_valid ? head.tval : '0;
    assign bus.out_pc    = bus.out_valid ? head.pc   : '0;
endmodule

// File: tb/tb_fuzz_exception_recorder.sv
// Scoreboard bench for fuzz_exception_recorder: reference queue model checked every cycle plus directed scenarios.
module tb_fuzz_exception_recorder;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] tval;
        logic [31:0] pc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        dexie_stall;
    logic [31:0] exc_count;
    logic [15:0] drop_count;
    logic        overflow;

    fuzz_exception_recorder_if bus();

    fuzz_exception_recorder #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear       (clear),
        .dexie_stall (dexie_stall),
        .exc_count   (exc_count),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    rec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_exc   = '0;
    logic [15:0] m_drop  = '0;
    logic        m_ovf   = 1'b0;
    logic        m_stall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Outputs are compared on the falling edge, then the model absorbs the inputs the next rising edge will see.
    always @(negedge clk) begin
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("out_code", {59'd0, bus.out_code}, {59'd0, exp_q[0].code});
            chk("out_tval", {32'd0, bus.out_tval}, {32'd0, exp_q[0].tval});
            chk("out_pc",   {32'd0, bus.out_pc},   {32'd0, exp_q[0].pc});
        end
        chk("dexie_stall", {63'd0, dexie_stall}, {63'd0, m_stall});
        chk("exc_count",   {32'd0, exc_count},   {32'd0, m_exc});
        chk("drop_count",  {48'd0, drop_count},  {48'd0, m_drop});
        chk("overflow",    {63'd0, overflow},    {63'd0, m_ovf});
        if (rst || clear) begin
            exp_q.delete();
            m_exc   = '0;
            m_drop  = '0;
            m_ovf   = 1'b0;
            m_stall = 1'b0;
        end else begin
            if (exp_q.size() != 0 && bus.out_ready) begin
                void'(exp_q.pop_front());
            end
            if (bus.exc_valid) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back('{code: bus.exc_code, tval: bus.exc_tval, pc: bus.exc_pc});
                    if (m_exc != 32'hFFFF_FFFF) m_exc = m_exc + 1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
                end
            end
            m_stall = (exp_q.size() >= DEPTH - MARGIN);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] code, input logic [31:0] tval, input logic [31:0] pc);
        bus.exc_valid = 1'b1;
        bus.exc_code  = code;
        bus.exc_tval  = tval;
        bus.exc_pc    = pc;
    endtask

    task automatic drain(input string tag, input int expected_pops);
        int pops;
        pops = 0;
        bus.exc_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 64 && bus.out_valid; c++) begin
            pops++;
            step();
        end
        if (expected_pops >= 0) chk(tag, 64'(pops), 64'(expected_pops));
        chk({tag, "_empty"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        clear         = 1'b0;
        bus.exc_valid = 1'b0;
        bus.exc_code  = '0;
        bus.exc_tval  = '0;
        bus.exc_pc    = '0;
        bus.out_ready = 1'b0;
        step();
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_stall", {63'd0, dexie_stall}, 64'd0);
        chk("rst_exc",   {32'd0, exc_count}, 64'd0);
        chk("rst_drop",  {48'd0, drop_count}, 64'd0);
        chk("rst_ovf",   {63'd0, overflow}, 64'd0);
        chk("rst_data",  {bus.out_tval, bus.out_pc}, 64'd0);
        chk("rst_code",  {59'd0, bus.out_code}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // Single exception with host ready: visible for exactly one cycle.
        bus.out_ready = 1'b1;
        drive(5'd2, 32'hDEAD_BEEF, 32'h0000_0100);
        step();
        bus.exc_valid = 1'b0;
        chk("single_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("single_code",  {59'd0, bus.out_code}, 64'd2);
        chk("single_tval",  {32'd0, bus.out_tval}, 64'hDEAD_BEEF);
        chk("single_pc",    {32'd0, bus.out_pc}, 64'h100);
        step();
        chk("single_gone",  {63'd0, bus.out_valid}, 64'd0);
        chk("single_count", {32'd0, exc_count}, 64'd1);

        // Ten pulses into a stalled host: 8 kept, 2 dropped, stall after the 6th.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(5'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i * 4));
            step();
            if (i == 4) chk("stall_after5", {63'd0, dexie_stall}, 64'd0);
            if (i == 5) chk("stall_after6", {63'd0, dexie_stall}, 64'd1);
        end
        bus.exc_valid = 1'b0;
        chk("full_drop",  {48'd0, drop_count}, 64'd2);
        chk("full_ovf",   {63'd0, overflow}, 64'd1);
        chk("full_count", {32'd0, exc_count}, 64'd9);

        // Push against a full FIFO while the head leaves: accepted, nothing dropped.
        bus.out_ready = 1'b1;
        drive(5'd7, 32'h3000, 32'h300);
        step();
        bus.exc_valid = 1'b0;
        chk("fullpp_drop",  {48'd0, drop_count}, 64'd2);
        chk("fullpp_count", {32'd0, exc_count}, 64'd10);
        drain("fullpp_pops", 8);

        // Back-to-back pushes with random host readiness; pointers wrap several times.
        for (int i = 0; i < 40; i++) begin
            drive(5'($urandom), $urandom, $urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain("rand_drain", -1);

        // Clear with 5 entries pending and a concurrent exception.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(5'(i), 32'h5000 + 32'(i), 32'h500 + 32'(i));
            step();
        end
        clear = 1'b1;
        drive(5'd31, 32'hBAD, 32'hBAD0);
        step();
        clear = 1'b0;
        bus.exc_valid = 1'b0;
        chk("clr_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("clr_count", {32'd0, exc_count}, 64'd0);
        chk("clr_ovf",   {63'd0, overflow}, 64'd0);
        chk("clr_drop",  {48'd0, drop_count}, 64'd0);
        bus.out_ready = 1'b1;
        drive(5'd3, 32'h44, 32'h400);
        step();
        bus.exc_valid = 1'b0;
        chk("clr_first_pc", {32'd0, bus.out_pc}, 64'h400);
        step();

        // Reset with 4 entries pending; first push afterwards emerges first.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(5'(i), 32'h6000 + 32'(i), 32'h600 + 32'(i));
            step();
        end
        bus.exc_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst2_stall", {63'd0, dexie_stall}, 64'd0);
        chk("rst2_count", {32'd0, exc_count}, 64'd0);
        chk("rst2_data",  {bus.out_tval, bus.out_pc}, 64'd0);
        drive(5'd1, 32'h55, 32'h200);
        bus.out_ready = 1'b1;
        step();
        bus.exc_valid = 1'b0;
        chk("rst2_first_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("rst2_first_pc",    {32'd0, bus.out_pc}, 64'h200);
        step();
        chk("rst2_count1", {32'd0, exc_count}, 64'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fuzz_exception_recorder.md
FUZZ_EXCEPTION_RECORDER -- requirements
Module: fuzz_exception_recorder

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, 4..64.
REQ-002 Parameter STALL_MARGIN, default 2: free-entry margin that triggers dexie_stall; 1..DEPTH-1.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 exc_valid  in  1  one-cycle exception pulse from core (fuzztr_exception_valid).
REQ-006 exc_code  in  5  mcause code.
REQ-007 exc_tval  in  32  mtval value.
REQ-008 exc_pc  in  32  mepc value.
REQ-009 dexie_stall  out  1  stall request to core, registered.
REQ-010 clear  in  1  synchronous flush of FIFO, counters, sticky flag.
REQ-011 out_valid  out  1  record available to host.
REQ-012 out_ready  in  1  host accepts record.
REQ-013 out_code  out  5; out_tval  out  32; out_pc  out  32  head record fields.
REQ-014 exc_count  out  32  accepted exceptions since reset/clear.
REQ-015 drop_count  out  16  exceptions dropped due to full FIFO.
REQ-016 overflow  out  1  sticky: at least one drop since reset/clear.

Function
REQ-017 Push = exc_valid sampled high; pop = out_valid && out_ready; both evaluated same edge.
REQ-018 Push accepted when occupancy < DEPTH, or occupancy == DEPTH with a pop in the same cycle.
REQ-019 Rejected push: entry discarded, drop_count +1 (saturating at 0xFFFF), overflow set.
REQ-020 Accepted push: exc_count +1, saturating at 0xFFFF_FFFF.
REQ-021 FIFO first-word-fall-through: out_valid high the cycle after the push edge into an empty FIFO; latency 1 cycle.
REQ-022 out_code/out_tval/out_pc show head entry; held stable while out_valid && !out_ready.
REQ-023 Push and pop on empty FIFO in same cycle impossible (out_valid low); push only.
REQ-024 Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
REQ-025 Read/write pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy log2(DEPTH)+1 bits.
REQ-026 dexie_stall registered: high the cycle after occupancy (post-update) >= DEPTH-STALL_MARGIN; low the cycle after occupancy drops below.
REQ-027 Module does not inspect exc_* when exc_valid low; no combinational path exc_valid -> dexie_stall.
REQ-028 clear has priority over push and pop: occupancy 0, pointers 0, counters 0, overflow 0 next cycle; concurrent exc_valid not stored, not counted.
REQ-029 out_valid drops to 0 the cycle after clear even if host was mid-handshake.

Reset
REQ-030 On rst: out_valid 0, dexie_stall 0, exc_count 0, drop_count 0, overflow 0, pointers/occupancy 0; out_* data 0.
REQ-031 rst overrides clear, push, pop; FIFO storage contents need not be reset.
REQ-032 rst mid-handshake discards all entries; first push after rst release stored normally.

Verification
REQ-033 Single exception (code 2, tval 0xDEAD_BEEF, pc 0x0000_0100), out_ready=1 -> out_valid one cycle, fields match, exc_count=1.
REQ-034 DEPTH=8, out_ready=0, 10 pulses -> 8 stored, drop_count=2, overflow=1, dexie_stall high from cycle after 6th push.
REQ-035 Full FIFO, out_ready=1 and exc_valid same cycle -> push accepted, drop_count unchanged, FIFO order intact over 8 pops.
REQ-036 Back-to-back pushes each cycle with random out_ready -> output sequence equals input sequence, pointers wrap past 7 correctly.
REQ-037 clear asserted with 5 entries and exc_valid=1 -> next cycle out_valid=0, exc_count=0, overflow=0, the concurrent exception absent.
REQ-038 rst asserted with 4 entries pending -> all outputs at REQ-030 values next cycle; subsequent push pc 0x200 emerges first.
